// File: rtl/eth_stats_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth_stats_pkg : register map and helpers for eth_stats_collector      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package eth_stats_pkg;

  // Event counters start at EV_BASE; stream counters follow the event block
  // at the offsets below.
  localparam int EV_BASE         = 0;
  localparam int TX_FRAMES       = 0;
  localparam int TX_BYTES        = 1;
  localparam int RX_FRAMES       = 2;
  localparam int RX_BYTES        = 3;
  localparam int NUM_STREAM_REGS = 4;

  function automatic int num_regs(input int num_events);
    return EV_BASE + num_events + NUM_STREAM_REGS;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_stats_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth_stats_counter : saturating live counter with snapshot shadow     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module eth_stats_counter #(
  parameter int WIDTH     = 32,
  parameter int INC_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [INC_WIDTH-1:0] inc_i,
  input  logic                 clear_i,
  input  logic                 snap_i,
  output logic [WIDTH-1:0]     live_o,
  output logic [WIDTH-1:0]     shadow_o
);

  localparam int SUM_W = WIDTH + 4;

  logic [WIDTH-1:0] live_q, live_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [SUM_W-1:0] sum_full;
  logic [SUM_W-1:0] sum_inc;

  function automatic logic [WIDTH-1:0] sat(input logic [SUM_W-1:0] s);
    return (s[SUM_W-1:WIDTH] != '0) ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  assign sum_full = SUM_W'(live_q) + SUM_W'(inc_i);
  assign sum_inc  = SUM_W'(inc_i);

  // On a clearing snap the live value restarts from this cycle's increment
  // so an event landing in the snap cycle is counted in both places.
  always_comb begin
    live_d   = sat(sum_full);
    shadow_d = shadow_q;
    if (snap_i) begin
      shadow_d = sat(sum_full);
      if (clear_i) begin
        live_d = sat(sum_inc);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q   <= '0;
      shadow_q <= '0;
    end else begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
    end
  end

  assign live_o   = live_q;
  assign shadow_o = shadow_q;

endmodule
`default_nettype wire

// File: rtl/eth_stats_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth_stats_collector : MAC event / frame / byte statistics with       |
// | atomic snapshot and 1-cycle read port.   Rev 1.0                     |
// +----------------------------------------------------------------------+
module eth_stats_collector #(
  parameter int NUM_EVENTS    = 9,
  parameter int CNT_WIDTH     = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int CLEAR_ON_SNAP = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [15:0]           status_i,
  input  logic [7:0]            tx_tkeep_i,
  input  logic                  tx_tvalid_i,
  input  logic                  tx_tready_i,
  input  logic                  tx_tlast_i,
  input  logic [7:0]            rx_tkeep_i,
  input  logic                  rx_tvalid_i,
  input  logic                  rx_tready_i,
  input  logic                  rx_tlast_i,
  input  logic                  snap_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ack_o,
  output logic [CNT_WIDTH-1:0]  rd_data_o
);
  import eth_stats_pkg::*;

  localparam int NUM_REGS    = num_regs(NUM_EVENTS);
  localparam int STREAM_BASE = EV_BASE + NUM_EVENTS;
  localparam int DEPTH       = 2 ** ADDR_WIDTH;

  logic                 tx_beat, rx_beat, clear;
  logic [3:0]           inc    [NUM_REGS];
  logic [CNT_WIDTH-1:0] live   [NUM_REGS];
  logic [CNT_WIDTH-1:0] shadow [DEPTH];
  logic                 rd_ack_q, rd_ack_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;

  assign tx_beat = tx_tvalid_i & tx_tready_i;
  assign rx_beat = rx_tvalid_i & rx_tready_i;
  assign clear   = snap_i & (CLEAR_ON_SNAP != 0);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i] = '0;
    end
    for (int i = 0; i < NUM_EVENTS; i++) begin
      inc[EV_BASE + i] = {3'b000, status_i[i]};
    end
    inc[STREAM_BASE + TX_FRAMES] = {3'b000, tx_beat & tx_tlast_i};
    inc[STREAM_BASE + TX_BYTES]  = tx_beat ? popcount8(tx_tkeep_i) : 4'd0;
    inc[STREAM_BASE + RX_FRAMES] = {3'b000, rx_beat & rx_tlast_i};
    inc[STREAM_BASE + RX_BYTES]  = rx_beat ? popcount8(rx_tkeep_i) : 4'd0;
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      eth_stats_counter #(
        .WIDTH     (CNT_WIDTH),
        .INC_WIDTH (4)
      ) u_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_i    (inc[gi]),
        .clear_i  (clear),
        .snap_i   (snap_i),
        .live_o   (live[gi]),
        .shadow_o (shadow[gi])
      );
    end
    // Unmapped addresses read back as zero.
    for (genvar gp = NUM_REGS; gp < DEPTH; gp++) begin : g_pad
      assign shadow[gp] = '0;
    end
  endgenerate

  always_comb begin
    rd_ack_d  = rd_req_i;
    rd_data_d = rd_req_i ? shadow[rd_addr_i] : rd_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire
